// File: rtl/mseq_chk.sv
// mseq_chk: self-synchronising checker for a Galois m-sequence stream with lock FSM and BER counters.
// Optional MSEQ_CHK_ZERO_DET_EN: while searching, a bit that leaves history and din all-zero counts as a mismatch.
module mseq_chk #(
  parameter int         W          = 4,
  parameter logic [W:0] POLY       = 5'b10011,
  parameter int         LOCK_CNT   = 8,
  parameter int         WIN_LEN    = 16,
  parameter int         UNLOCK_ERR = 4,
  parameter int         CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             din,
  input  logic             din_vld,
  input  logic             clr,
  output logic             locked,
  output logic             err_pulse,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] bit_cnt
);
  typedef enum logic [1:0] {S_FILL, S_SEARCH, S_LOCK} state_t;

  state_t        state, state_nxt;
  logic [W-1:0]  hist;
  logic [4:0]    fill_cnt;
  logic [7:0]    run;
  logic [15:0]   win_cnt, win_err;
  logic          pred, mism, srch_bad, fill_done, run_done, unlock, win_done;

  always_comb begin
    pred = ^(POLY[W:1] & hist);
    mism = din ^ pred;
`ifdef MSEQ_CHK_ZERO_DET_EN
    srch_bad = mism | ({hist[W-2:0], din} == '0);
`else
    srch_bad = mism;
`endif
    fill_done = (fill_cnt == 5'(W - 1));
    run_done  = !srch_bad && (run == 8'(LOCK_CNT - 1));
    unlock    = mism && (win_err == 16'(UNLOCK_ERR - 1));
    win_done  = (win_cnt == 16'(WIN_LEN - 1));
    state_nxt = state;
    if (din_vld) begin
      case (state)
        S_FILL:   if (fill_done) state_nxt = S_SEARCH;
        S_SEARCH: if (run_done)  state_nxt = S_LOCK;
        S_LOCK:   if (unlock)    state_nxt = S_FILL;
        default:                 state_nxt = S_FILL;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_FILL;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist      <= '0;
      fill_cnt  <= '0;
      run       <= '0;
      win_cnt   <= '0;
      win_err   <= '0;
      locked    <= 1'b0;
      err_pulse <= 1'b0;
      err_cnt   <= '0;
      bit_cnt   <= '0;
    end else begin
      err_pulse <= 1'b0;
      locked    <= (state_nxt == S_LOCK);
      if (din_vld) begin
        case (state)
          S_FILL: begin
            hist     <= {hist[W-2:0], din};
            fill_cnt <= fill_done ? 5'd0 : fill_cnt + 5'd1;
            run      <= '0;
          end
          S_SEARCH: begin
            hist <= {hist[W-2:0], din};
            run  <= (srch_bad || run_done) ? 8'd0 : run + 8'd1;
            if (run_done) begin
              win_cnt <= '0;
              win_err <= '0;
            end
          end
          S_LOCK: begin
            // Flywheel on the local prediction so one channel error costs exactly one count.
            hist <= {hist[W-2:0], pred};
            if (bit_cnt != '1) bit_cnt <= bit_cnt + CNT_W'(1);
            if (mism) begin
              err_pulse <= 1'b1;
              if (err_cnt != '1) err_cnt <= err_cnt + CNT_W'(1);
            end
            if (unlock || win_done) begin
              win_cnt  <= '0;
              win_err  <= '0;
              fill_cnt <= '0;
            end else begin
              win_cnt <= win_cnt + 16'd1;
              win_err <= win_err + 16'(mism);
            end
          end
          default: ;
        endcase
      end
      if (clr) begin
        err_pulse <= 1'b0;
        err_cnt   <= '0;
        bit_cnt   <= '0;
      end
    end
  end
endmodule

// File: tb/tb_mseq_chk.sv
// Directed bench for mseq_chk: per-bit expectations queued on drive, checked by a negedge monitor.
module tb_mseq_chk;
  logic clk = 1'b0, rst_n = 1'b0, din = 1'b0, din_vld = 1'b0, clr = 1'b0;
  logic locked, err_pulse, s_locked, s_err_pulse;
  logic [15:0] err_cnt, bit_cnt;
  logic [3:0]  s_err_cnt, s_bit_cnt;

  mseq_chk u_dut (.clk(clk), .rst_n(rst_n), .din(din), .din_vld(din_vld), .clr(clr),
                  .locked(locked), .err_pulse(err_pulse), .err_cnt(err_cnt), .bit_cnt(bit_cnt));
  mseq_chk #(.CNT_W(4)) u_sat (.clk(clk), .rst_n(rst_n), .din(din), .din_vld(din_vld), .clr(clr),
                  .locked(s_locked), .err_pulse(s_err_pulse), .err_cnt(s_err_cnt), .bit_cnt(s_bit_cnt));

  always #5 clk = ~clk;

  typedef struct packed { logic lk; logic pl; } exp_t;
  exp_t q[$];
  exp_t e;
  int   ncmp = 0, nerr = 0, idx = 0;
  bit   seq [15] = '{1,0,1,0,1,1,0,0,1,0,0,0,1,1,1};
  logic sampled = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    ncmp++;
    assert (obs === expv) else begin
      nerr++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic send_raw(input bit d, input bit elk, input bit epl);
    din = d; din_vld = 1'b1;
    q.push_back('{lk: elk, pl: epl});
    @(posedge clk); #1;
    din_vld = 1'b0;
  endtask

  task automatic send(input bit inv, input bit elk, input bit epl);
    bit b;
    b = seq[idx] ^ inv;
    idx = (idx + 1) % 15;
    send_raw(b, elk, epl);
  endtask

  task automatic gap(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  always @(posedge clk) sampled <= din_vld & rst_n;

  always @(negedge clk) begin
    if (sampled) begin
      if (q.size() == 0) begin
        ncmp++; nerr++;
        $error("FAIL queue: observed empty expected entry");
      end else begin
        e = q.pop_front();
        chk("locked", locked, e.lk);
        chk("err_pulse", err_pulse, e.pl);
      end
    end else if (rst_n) begin
      chk("idle_pulse", err_pulse, 0);
    end
  end

  initial begin
    #1000000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    // reset state
    gap(2);
    chk("rst_locked", locked, 0);
    chk("rst_pulse", err_pulse, 0);
    chk("rst_err_cnt", err_cnt, 0);
    chk("rst_bit_cnt", bit_cnt, 0);
    rst_n = 1'b1;
    gap(1);

    // clean lock at the 12th bit, then 100 checked bits
    for (int i = 1; i <= 12; i++) send(0, i >= 12, 0);
    for (int i = 0; i < 100; i++) send(0, 1, 0);
    chk("clean_bit_cnt", bit_cnt, 100);
    chk("clean_err_cnt", err_cnt, 0);
    chk("sat_bit_cnt", s_bit_cnt, 15);

    // single error keeps lock
    send(1, 1, 1);
    for (int i = 0; i < 20; i++) send(0, 1, 0);
    chk("single_err_cnt", err_cnt, 1);
    chk("single_bit_cnt", bit_cnt, 121);

    // four errors in one window drop lock, relock 12 bits later
    for (int i = 0; i < 3; i++) send(1, 1, 1);
    send(1, 0, 1);
    chk("unlock_err_cnt", err_cnt, 5);
    for (int i = 1; i <= 12; i++) send(0, i >= 12, 0);
    chk("relock_bit_cnt", bit_cnt, 125);
    chk("relock_locked", locked, 1);

    // gapped valid with one error
    for (int i = 0; i < 50; i++) begin
      send(i == 25, 1, i == 25);
      gap($urandom_range(0, 3));
    end
    chk("gap_bit_cnt", bit_cnt, 175);
    chk("gap_err_cnt", err_cnt, 6);

    // clr coincident with a counted bit wins
    clr = 1'b1;
    send(0, 1, 0);
    clr = 1'b0;
    chk("clr_err_cnt", err_cnt, 0);
    chk("clr_bit_cnt", bit_cnt, 0);
    chk("clr_sat_bit", s_bit_cnt, 0);
    for (int i = 0; i < 5; i++) send(0, 1, 0);
    chk("post_clr_bit", bit_cnt, 5);

    // 20 spaced errors: 2 per window, saturating the 4-bit copy
    for (int i = 0; i < 20; i++) begin
      send(1, 1, 1);
      for (int j = 0; j < 7; j++) send(0, 1, 0);
    end
    chk("spaced_err_cnt", err_cnt, 20);
    chk("spaced_bit_cnt", bit_cnt, 165);
    chk("sat_err_cnt", s_err_cnt, 15);
    chk("sat_bit_cnt2", s_bit_cnt, 15);
    chk("sat_locked", s_locked, 1);

    // asynchronous reset mid-lock, while an err_pulse is high
    send(1, 1, 1);
    @(negedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("arst_locked", locked, 0);
    chk("arst_pulse", err_pulse, 0);
    chk("arst_err_cnt", err_cnt, 0);
    chk("arst_bit_cnt", bit_cnt, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    gap(1);

    // stuck-at-zero stream
    for (int i = 1; i <= 1000; i++) begin
`ifdef MSEQ_CHK_ZERO_DET_EN
      send_raw(0, 0, 0);
`else
      send_raw(0, i >= 12, 0);
`endif
    end

    gap(2);
    chk("queue_drained", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
